// File: rtl/seq_mult_param_if.sv
// Request/result bundle for the parametrised shift-add multiplier.
// Handshake: a request is taken on a rising clock edge where start=1 and ready=1;
// valid=1 means prodt holds a finished product, and prodt stays stable until the next SIGN cycle.
interface seq_mult_param_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   mlier;
  logic [WIDTH-1:0]   mcand;
  logic               ready;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] prodt;

  modport master (
    output start, is_signed, mlier, mcand,
    input  ready, busy, valid, prodt
  );

  modport slave (
    input  start, is_signed, mlier, mcand,
    output ready, busy, valid, prodt
  );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier: magnitude multiply over WIDTH cycles, then one sign-fix cycle.
// Signed and unsigned operands are selected per operation; the product is held until the next result.
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  seq_mult_param_if.slave  bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand_sft;
  logic [WIDTH-1:0]     mlier_sft;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_flag;
  logic [2*WIDTH-1:0]   prodt;
  logic                 valid;

  // Negating the most-negative value yields 2^(W-1), which still fits as an unsigned magnitude.
  logic [WIDTH-1:0]     mlier_mag;
  logic [WIDTH-1:0]     mcand_mag;

  assign mlier_mag = (bus.is_signed && bus.mlier[WIDTH-1]) ? -bus.mlier : bus.mlier;
  assign mcand_mag = (bus.is_signed && bus.mcand[WIDTH-1]) ? -bus.mcand : bus.mcand;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand_sft <= '0;
      mlier_sft <= '0;
      cnt       <= '0;
      neg_flag  <= 1'b0;
      prodt     <= '0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mlier_sft <= mlier_mag;
            mcand_sft <= {{WIDTH{1'b0}}, mcand_mag};
            neg_flag  <= bus.is_signed & (bus.mlier[WIDTH-1] ^ bus.mcand[WIDTH-1]);
            acc       <= '0;
            cnt       <= '0;
            valid     <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          if (mlier_sft[0]) begin
            acc <= acc + mcand_sft;
          end
          mcand_sft <= mcand_sft << 1;
          mlier_sft <= mlier_sft >> 1;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          // A zero magnitude is never negated, so no -0 result appears.
          prodt <= (neg_flag && (acc != '0)) ? -acc : acc;
          valid <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prodt = prodt;
  assign bus.valid = valid;
  assign bus.busy  = (state == CALC) || (state == SIGN);
  assign bus.ready = ~bus.busy;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: a WIDTH=32 instance for corners/handshake and a WIDTH=8 instance for a sweep.
// Expected products are hand-computed constants or a plain multiply of sign-extended operands.
module tb_seq_mult_param;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  seq_mult_param_if #(.WIDTH(32)) bus32 ();
  seq_mult_param_if #(.WIDTH(8))  bus8 ();
  logic [1:0] st32;
  logic [1:0] st8;

  seq_mult_param #(.WIDTH(32)) u_dut32 (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus32.slave),
    .state_dbg (st32)
  );

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus8.slave),
    .state_dbg (st8)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (WIDTH=32) ----------------
  task automatic launch32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clock);
    while (!bus32.ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("ready32_timeout", 64'(bus32.ready), 64'd1);
    bus32.is_signed = sgn;
    bus32.mlier     = a;
    bus32.mcand     = b;
    bus32.start     = 1'b1;
    @(posedge clock);
    #1;
    bus32.start = 1'b0;
  endtask

  // Counts edges after the accept edge until valid is seen; lat starts at the edges already elapsed.
  task automatic wait_valid32(input int already, output int lat);
    lat = already;
    while (!bus32.valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (lat >= 100) check("valid32_timeout", 64'(bus32.valid), 64'd1);
  endtask

  task automatic op32(input string tag, input logic sgn, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
    int lat;
    launch32(sgn, a, b);
    wait_valid32(0, lat);
    check({tag, "_prod"}, bus32.prodt, exp);
    check({tag, "_lat"}, 64'(lat), 64'd33);
  endtask

  // ---------------- driver task (WIDTH=8) ----------------
  task automatic op8(input string tag, input logic sgn, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp);
    int n = 0;
    int lat = 0;
    @(negedge clock);
    while (!bus8.ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("ready8_timeout", 64'(bus8.ready), 64'd1);
    bus8.is_signed = sgn;
    bus8.mlier     = a;
    bus8.mcand     = b;
    bus8.start     = 1'b1;
    @(posedge clock);
    #1;
    bus8.start = 1'b0;
    while (!bus8.valid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_prod"}, 64'(bus8.prodt), 64'(exp));
    check({tag, "_lat"}, 64'(lat), 64'd9);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    int x;
    int y;
    logic [15:0] e16;

    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.mlier = '0; bus32.mcand = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.mlier  = '0; bus8.mcand  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_prodt", bus32.prodt, 64'd0);
    check("rst_valid", 64'(bus32.valid), 64'd0);
    check("rst_ready", 64'(bus32.ready), 64'd1);
    check("rst_busy", 64'(bus32.busy), 64'd0);
    check("rst_state", 64'(st32), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Signed corners
    op32("s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    op32("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);

    // DONE holds the product; a new accept drops valid but keeps prodt until SIGN
    repeat (5) @(posedge clock);
    #1;
    check("done_hold_prod", bus32.prodt, 64'hFFFF_FFFF_FFFF_FFEB);
    check("done_hold_valid", 64'(bus32.valid), 64'd1);
    launch32(1'b1, 32'd0, 32'hFFFF_FFF7);
    check("redo_valid_drop", 64'(bus32.valid), 64'd0);
    check("redo_prod_kept", bus32.prodt, 64'hFFFF_FFFF_FFFF_FFEB);
    repeat (20) begin
      @(posedge clock);
      #1;
    end
    check("redo_prod_mid", bus32.prodt, 64'hFFFF_FFFF_FFFF_FFEB);
    check("redo_busy_mid", 64'(bus32.busy), 64'd1);
    wait_valid32(20, lat);
    check("s_0xm9_prod", bus32.prodt, 64'd0);
    check("s_0xm9_lat", 64'(lat), 64'd33);

    // Unsigned vs signed on all-ones operands
    op32("u_maxmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    op32("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    // Reset mid-CALC aborts with no output
    launch32(1'b0, 32'd5, 32'd7);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_prodt", bus32.prodt, 64'd0);
    check("abort_valid", 64'(bus32.valid), 64'd0);
    check("abort_ready", 64'(bus32.ready), 64'd1);
    check("abort_state", 64'(st32), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    op32("u_5x7", 1'b0, 32'd5, 32'd7, 64'd35);

    // start while busy is ignored
    launch32(1'b0, 32'd6, 32'd7);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    bus32.mlier = 32'd9; bus32.mcand = 32'd9; bus32.is_signed = 1'b1; bus32.start = 1'b1;
    @(posedge clock);
    #1;
    bus32.start = 1'b0;
    wait_valid32(4, lat);
    check("busy_ign_prod", bus32.prodt, 64'd42);
    check("busy_ign_lat", 64'(lat), 64'd33);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("busy_ign_noq_valid", 64'(bus32.valid), 64'd1);
    check("busy_ign_noq_state", 64'(st32), 64'd3);

    // start held high: back-to-back products, operands changed in each DONE cycle
    @(negedge clock);
    bus32.is_signed = 1'b0; bus32.mlier = 32'd3; bus32.mcand = 32'd4; bus32.start = 1'b1;
    @(posedge clock);
    #1;
    wait_valid32(0, lat);
    check("b2b0_prod", bus32.prodt, 64'd12);
    check("b2b0_lat", 64'(lat), 64'd33);
    bus32.mlier = 32'd100; bus32.mcand = 32'd200;
    @(posedge clock);
    #1;
    check("b2b1_drop", 64'(bus32.valid), 64'd0);
    wait_valid32(0, lat);
    check("b2b1_prod", bus32.prodt, 64'd20000);
    check("b2b1_lat", 64'(lat), 64'd33);
    bus32.mlier = 32'h0001_0000; bus32.mcand = 32'h0001_0000;
    @(posedge clock);
    #1;
    check("b2b2_drop", 64'(bus32.valid), 64'd0);
    bus32.start = 1'b0;
    wait_valid32(0, lat);
    check("b2b2_prod", bus32.prodt, 64'h0000_0001_0000_0000);
    check("b2b2_lat", 64'(lat), 64'd33);

    // WIDTH=8 corners and strided sweep in both modes
    op8("w8_s_minmin", 1'b1, 8'h80, 8'h80, 16'h4000);
    op8("w8_u_8080", 1'b0, 8'h80, 8'h80, 16'h4000);
    op8("w8_s_m1x127", 1'b1, 8'hFF, 8'h7F, 16'hFF81);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i += 15) begin
        for (int j = 0; j < 256; j += 15) begin
          x = (s == 1 && i >= 128) ? i - 256 : i;
          y = (s == 1 && j >= 128) ? j - 256 : j;
          e16 = 16'(x * y);
          op8("w8_sweep", s[0], 8'(i), 8'(j), e16);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
